pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised elastic pipeline register that replaces the fixed-width, stall/flush-driven inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RV32I core with a valid/ready handshake. It carries an opaque data payload plus a separate control field that is forced to zero whenever the stage holds a bubble. An optional two-entry skid buffer gives full throughput with a registered `in_ready`. A saturating counter reports back-pressure cycles for performance debug.

## Interface
- `DATA_W`, default 69: payload width (e.g. alu_result 32 + store data 32 + rd 5).
- `CTRL_W`, default 3: control-field width (e.g. mem_write, mem_read, reg_write).
- `CNT_W`, default 16: stall-counter width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous kill of all held entries and of the current input beat.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_data`  in  DATA_W  upstream payload.
- `in_ctrl`  in  CTRL_W  upstream control field.
- `out_valid`  out  1  downstream beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `out_data`  out  DATA_W  head-entry payload.
- `out_ctrl`  out  CTRL_W  head-entry control; all-zero whenever `out_valid`=0.
- `stall_cnt`  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Accept: `in_valid && in_ready && !flush`. Pop: `out_valid && out_ready`.
- Entries hold {data, ctrl, valid}. Order is strictly FIFO. No beat is duplicated or dropped, except by flush.
- Bubble rule: `out_ctrl` = head ctrl when valid, else 0. `out_data` retains its last value when invalid; it is not cleared.
- Flush:
  - Has priority over accept and pop.
  - Next cycle all valids = 0 and stored ctrl = 0; payload registers keep their old values.
  - A beat presented during the flush cycle is discarded, even if `in_ready`=1.
  - A pop in the flush cycle still counts as delivered downstream.
- `stall_cnt`:
  - Increments every cycle with `out_valid && !out_ready && !flush`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.
- Reset mid-operation: all entries are invalidated immediately and asynchronously, and in-flight beats are lost.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_ctrl`=0, `stall_cnt`=0, `in_ready`=1.
- Latency: an accepted beat appears on `out_*` on the next edge. There is no combinational `in_*` → `out_*` path.
- Single-register mode (macro off):
  - `in_ready` = `!out_valid || out_ready`, which is combinational from `out_ready`.
  - Simultaneous accept and pop when full replaces the head in the same edge, giving 1 beat/cycle.
- Skid mode (macro on):
  - States are EMPTY, ONE, FULL.
  - EMPTY + accept → ONE.
  - ONE + accept + pop → ONE.
  - ONE + accept + no pop → FULL; the new beat goes to the skid slot.
  - ONE + pop only → EMPTY.
  - FULL + pop → ONE; the skid slot moves to head.
  - Any state + flush → EMPTY.
  - `in_ready` = (state ≠ FULL) and is driven straight from a flop.
  - When FULL, an `in_valid` beat is refused and holds upstream.
- `stall_cnt` updates one edge after the qualifying cycle.

## Configuration
- `PIPE_SKID_EN` defined: two-entry skid buffer with registered `in_ready` and 3-state occupancy FSM.
- `PIPE_SKID_EN` undefined: single entry with combinational `in_ready` and a 1-bit occupancy.
- In both modes the ports, latency, flush and `stall_cnt` behaviour are identical.

## Structure
- Shared package `pipe_pkg` holds:
  - the occupancy enum `pipe_occ_t` (EMPTY, ONE, FULL);
  - the default width constants `PIPE_EXMEM_DATA_W`=69 and `PIPE_EXMEM_CTRL_W`=3.
- Sub-module `pipe_sat_counter` (params `CNT_W`; ports `clk`, `reset`, `inc`, `cnt`) implements the saturating stall counter.
- The entry storage and FSM stay in `pipe_stage_reg`.

## Test plan
- Reset, then `in_valid`=1 with `in_data`=0x0AA, `in_ctrl`=3'b101 and `out_ready`=1 → one edge later `out_valid`=1, `out_data`=0x0AA, `out_ctrl`=3'b101.
- Stream 8 beats (data 1..8) with `out_ready`=1 continuously → 8 consecutive outputs 1..8, one per cycle, in both macro settings.
- Hold `out_ready`=0 while streaming 1, 2, 3 with skid on → `in_ready`=0 after 2 accepts. Beat 3 is held. After `out_ready` rises, outputs are 1, 2, 3 with no gap, and `stall_cnt` equals the number of held cycles.
- Stage FULL (data 5, 6) with flush=1 and `in_valid`=1 (data 7) in the same cycle → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1, and 7 never appears.
- Hold `out_valid`=1 with `out_ready`=0 for 2^CNT_W+3 cycles (CNT_W=4) → `stall_cnt` sticks at 15.
- Assert `reset` asynchronously mid-stream between edges → outputs reach their reset values without waiting for an edge, and the stream restarts cleanly after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_occ_t;

  localparam int PIPE_EXMEM_DATA_W = 69;
  localparam int PIPE_EXMEM_CTRL_W = 3;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used to count back-pressured cycles of a pipe stage.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with bubble-zeroed control field.
// Define PIPE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_EXMEM_DATA_W,
  parameter int CTRL_W = PIPE_EXMEM_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a beat moves only on a cycle where valid and ready are both
  // high at the rising edge; flush kills every held entry and the input beat.
  logic              accept;
  logic              pop;
  logic [DATA_W-1:0] data0_q;
  logic [CTRL_W-1:0] ctrl0_q;

`ifdef PIPE_SKID_EN
  pipe_occ_t         state_q;
  logic              in_ready_q;
  logic [DATA_W-1:0] data1_q;
  logic [CTRL_W-1:0] ctrl1_q;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q && !flush;
  assign pop       = out_valid && out_ready;

  // Slot 0 is always the head; slot 1 only catches a beat that arrives while
  // the head is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      data0_q    <= '0;
      ctrl0_q    <= '0;
      data1_q    <= '0;
      ctrl1_q    <= '0;
    end else if (flush) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      ctrl0_q    <= '0;
      ctrl1_q    <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            data0_q <= in_data;
            ctrl0_q <= in_ctrl;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            data0_q <= in_data;
            ctrl0_q <= in_ctrl;
          end else if (accept) begin
            data1_q    <= in_data;
            ctrl1_q    <= in_ctrl;
            state_q    <= FULL;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            ctrl0_q <= '0;
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            data0_q    <= data1_q;
            ctrl0_q    <= ctrl1_q;
            ctrl1_q    <= '0;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  logic valid_q;

  assign out_valid = valid_q;
  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data0_q <= '0;
      ctrl0_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl0_q <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data0_q <= in_data;
      ctrl0_q <= in_ctrl;
    end else if (pop) begin
      valid_q <= 1'b0;
      ctrl0_q <= '0;
    end
  end
`endif

  // Stored ctrl is zeroed whenever the head goes empty, so it can drive the
  // port directly and stay registered.
  assign out_data = data0_q;
  assign out_ctrl = ctrl0_q;

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !out_ready && !flush),
    .cnt   (stall_cnt)
  );

endmodule
